// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO plus launch controller feeding a uart_tx.
// Pops one byte per frame and keeps tx_din stable from launch until tx_done.
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic [7:0]    tx_din,
  output logic          tx_start,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          temt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overrun_q, overrun_d;
  logic          temt_q, temt_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    tx_din_q, tx_din_d;
  logic          tx_start_q, tx_start_d;

  logic          push;
  logic          pop;

  // full is the registered pre-edge flag, so a same-cycle pop never admits a write into a full FIFO
  assign push = wr_en && !full_q && !flush;
  assign pop  = (state_q == ST_IDLE) && !empty_q && !tx_busy;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overrun_d = wr_en && full_q && !flush;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Launch controller: a pop under flush still latches the head, flush never touches the FSM
  always_comb begin
    state_d    = state_q;
    tx_din_d   = tx_din_q;
    tx_start_d = tx_start_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_din_d   = mem[rptr_q];
          tx_start_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    temt_d = empty_d && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overrun_q  <= 1'b0;
      temt_q     <= 1'b1;
      state_q    <= ST_IDLE;
      tx_din_q   <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overrun_q  <= overrun_d;
      temt_q     <= temt_d;
      state_q    <= state_d;
      tx_din_q   <= tx_din_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_din   = tx_din_q;
  assign tx_start = tx_start_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign temt     = temt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo, paired with a behavioural 16x-oversampled uart_tx
// (tick every 4 clk, 8N1) that rebuilds each frame from tx_din bit by bit.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_din;
  logic       tx_start;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overrun;
  logic       temt;

  int vecCount = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_din(tx_din), .tx_start(tx_start),
    .full(full), .empty(empty), .count(count), .overrun(overrun), .temt(temt)
  );

  // Transmitter model: samples tx_start on a tick, then 10 bit periods of 16 ticks each
  logic       tickEnable = 1'b1;
  logic       busyHold = 1'b0;
  logic [1:0] tickCnt;
  logic       mBusy, mDone, mTxd;
  logic [3:0] mPhase, mSub;
  logic [7:0] mShift;
  logic       tick;

  assign tick    = tickEnable && (tickCnt == 2'd3);
  assign tx_busy = mBusy | busyHold;
  assign tx_done = mDone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt <= 2'd0;
      mBusy   <= 1'b0;
      mDone   <= 1'b0;
      mTxd    <= 1'b1;
      mPhase  <= 4'd0;
      mSub    <= 4'd0;
      mShift  <= 8'h00;
    end else begin
      tickCnt <= tickCnt + 2'd1;
      mDone   <= 1'b0;
      if (!mBusy) begin
        if (tick && tx_start) begin
          mBusy  <= 1'b1;
          mPhase <= 4'd0;
          mSub   <= 4'd0;
          mTxd   <= 1'b0;
        end
      end else if (tick) begin
        if (mSub == 4'd15) begin
          mSub <= 4'd0;
          if (mPhase == 4'd9) begin
            mBusy <= 1'b0;
            mDone <= 1'b1;
            mTxd  <= 1'b1;
          end else begin
            mPhase <= mPhase + 4'd1;
            if (mPhase < 4'd8) begin
              mTxd   <= tx_din[mPhase[2:0]];
              mShift <= {tx_din[mPhase[2:0]], mShift[7:1]};
            end else begin
              mTxd <= 1'b1;
            end
          end
        end else begin
          mSub <= mSub + 4'd1;
        end
      end
    end
  end

  logic [7:0] rxMem [0:63];
  int rxCount = 0;
  int ovCount = 0;

  always @(posedge clk) begin
    if (mDone) begin
      rxMem[rxCount] <= mShift;
      rxCount <= rxCount + 1;
    end
    if (overrun) begin
      ovCount <= ovCount + 1;
    end
  end

  task automatic writeByte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic waitRx(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rxCount >= target && temt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitBusy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    vecCount++;
    if ({empty, full, count, tx_start, tx_din, temt, overrun} !== {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      missCount++;
      $display("[TB] FAIL reset_state: got empty=%b full=%b count=%0d start=%b din=%h temt=%b ovr=%b, want 1 0 0 0 00 1 0",
               empty, full, count, tx_start, tx_din, temt, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    bit ok;
    int base = rxCount;
    writeByte(8'hA5);
    vecCount++;
    if ({empty, tx_start, count} !== {1'b0, 1'b0, 5'd1}) begin
      missCount++;
      $display("[TB] FAIL single_plus1: got empty=%b start=%b count=%0d, want 0 0 1", empty, tx_start, count);
    end
    @(negedge clk);
    vecCount++;
    if ({tx_start, tx_din, count, temt} !== {1'b1, 8'hA5, 5'd0, 1'b0}) begin
      missCount++;
      $display("[TB] FAIL single_launch: got start=%b din=%h count=%0d temt=%b, want 1 a5 0 0", tx_start, tx_din, count, temt);
    end
    waitBusy(20, ok);
    vecCount++;
    if (!ok || tx_start !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL single_busy: got busy_seen=%b start=%b, want 1 1", ok, tx_start);
    end
    @(negedge clk);
    vecCount++;
    if (tx_start !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL single_start_drop: got start=%b, want 0", tx_start);
    end
    waitRx(base + 1, 800, ok);
    vecCount++;
    if (!ok || rxMem[base] !== 8'hA5 || temt !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL single_serial: got done=%b byte=%h temt=%b, want 1 a5 1", ok, rxMem[base], temt);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    int base = rxCount;
    int ovBase = ovCount;
    busyHold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      @(negedge clk);
      if (i == 14) begin
        vecCount++;
        if ({full, count} !== {1'b0, 5'd15}) begin
          missCount++;
          $display("[TB] FAIL ovf_15: got full=%b count=%0d, want 0 15", full, count);
        end
      end
      if (i == 15) begin
        vecCount++;
        if ({full, count, overrun} !== {1'b1, 5'd16, 1'b0}) begin
          missCount++;
          $display("[TB] FAIL ovf_16: got full=%b count=%0d ovr=%b, want 1 16 0", full, count, overrun);
        end
      end
    end
    wr_en = 1'b0;
    vecCount++;
    if ({overrun, count, full} !== {1'b1, 5'd16, 1'b1}) begin
      missCount++;
      $display("[TB] FAIL ovf_pulse: got ovr=%b count=%0d full=%b, want 1 16 1", overrun, count, full);
    end
    @(negedge clk);
    vecCount++;
    if (overrun !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL ovf_pulse_end: got ovr=%b, want 0", overrun);
    end
    busyHold = 1'b0;
    waitRx(base + 16, 16 * 700, ok);
    vecCount++;
    if (!ok || empty !== 1'b1 || ovCount - ovBase != 1) begin
      missCount++;
      $display("[TB] FAIL ovf_drain: got done=%b empty=%b overruns=%0d, want 1 1 1", ok, empty, ovCount - ovBase);
    end
    for (int k = 0; k < 16; k++) begin
      vecCount++;
      if (rxMem[base + k] !== 8'(k)) begin
        missCount++;
        $display("[TB] FAIL ovf_order[%0d]: got %h, want %h", k, rxMem[base + k], 8'(k));
      end
    end
  endtask

  task automatic test_flush;
    bit ok;
    int base = rxCount;
    int ovBase = ovCount;
    writeByte(8'h11);
    writeByte(8'h22);
    writeByte(8'h33);
    waitBusy(20, ok);
    repeat (100) @(negedge clk);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h44;
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    vecCount++;
    if (!ok || {count, empty, tx_din, overrun} !== {5'd0, 1'b1, 8'h11, 1'b0}) begin
      missCount++;
      $display("[TB] FAIL flush_state: got busy_seen=%b count=%0d empty=%b din=%h ovr=%b, want 1 0 1 11 0",
               ok, count, empty, tx_din, overrun);
    end
    waitRx(base + 1, 800, ok);
    repeat (1500) @(negedge clk);
    vecCount++;
    if (!ok || rxCount != base + 1 || rxMem[base] !== 8'h11 || ovCount != ovBase || temt !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL flush_result: got done=%b sent=%0d first=%h overruns=%0d temt=%b, want 1 1 11 0 1",
               ok, rxCount - base, rxMem[base], ovCount - ovBase, temt);
    end
  endtask

  task automatic test_stall;
    bit ok;
    int base = rxCount;
    tickEnable = 1'b0;
    writeByte(8'h5A);
    @(negedge clk);
    repeat (50) @(negedge clk);
    vecCount++;
    if ({tx_start, tx_din, tx_busy} !== {1'b1, 8'h5A, 1'b0}) begin
      missCount++;
      $display("[TB] FAIL stall_hold: got start=%b din=%h busy=%b, want 1 5a 0", tx_start, tx_din, tx_busy);
    end
    tickEnable = 1'b1;
    waitBusy(20, ok);
    vecCount++;
    if (!ok || tx_start !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL stall_resume: got busy_seen=%b start=%b, want 1 1", ok, tx_start);
    end
    @(negedge clk);
    vecCount++;
    if (tx_start !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL stall_drop: got start=%b, want 0", tx_start);
    end
    waitRx(base + 1, 800, ok);
    vecCount++;
    if (!ok || rxMem[base] !== 8'h5A) begin
      missCount++;
      $display("[TB] FAIL stall_serial: got done=%b byte=%h, want 1 5a", ok, rxMem[base]);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int base = rxCount;
    writeByte(8'hC3);
    writeByte(8'h01);
    writeByte(8'h02);
    writeByte(8'h03);
    waitBusy(20, ok);
    repeat (200) @(negedge clk);
    vecCount++;
    if (!ok || count !== 5'd3 || tx_din !== 8'hC3) begin
      missCount++;
      $display("[TB] FAIL midrst_pre: got busy_seen=%b count=%0d din=%h, want 1 3 c3", ok, count, tx_din);
    end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if ({empty, full, count, tx_start, tx_din, temt, overrun} !== {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      missCount++;
      $display("[TB] FAIL midrst_async: got empty=%b full=%b count=%0d start=%b din=%h temt=%b ovr=%b, want 1 0 0 0 00 1 0",
               empty, full, count, tx_start, tx_din, temt, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    vecCount++;
    if (rxCount != base || tx_start !== 1'b0 || temt !== 1'b1 || count !== 5'd0) begin
      missCount++;
      $display("[TB] FAIL midrst_after: got sent=%0d start=%b temt=%b count=%0d, want 0 0 1 0",
               rxCount - base, tx_start, temt, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_flush();
    test_stall();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
